// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin TX scheduler sharing one MII/GMII byte stream between ARP and UDP generators
module eth_tx_sched #(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 32,
  parameter int MAX_FRAME     = 1530,
  parameter int CNT_W         = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_enable,
  input  logic [7:0] i_arp_tx_data,
  input  logic       i_arp_tx_en,
  input  logic [7:0] i_udp_tx_data,
  input  logic       i_udp_tx_en,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_busy,
  output logic [1:0] o_done,
  output logic [1:0] o_err,
  output logic [1:0] o_pending
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_DRAIN,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_MAX  = CNT_W'(MAX_FRAME);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  state_t           state, state_nxt;
  logic             sel, sel_nxt;
  logic             last_grant, last_grant_nxt;
  logic [1:0]       pending_nxt;
  logic [1:0]       grant;
  logic [1:0]       sel_oh;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]       enable_nxt, done_nxt, err_nxt;
  logic             tx_en_nxt;
  logic [7:0]       tx_data_nxt;
  logic             g_en;
  logic [7:0]       g_data;

  assign o_busy  = (state != S_IDLE);
  assign sel_oh  = sel ? 2'b10 : 2'b01;
  assign g_en    = sel ? i_udp_tx_en : i_arp_tx_en;
  assign g_data  = sel ? i_udp_tx_data : i_arp_tx_data;
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    grant          = 2'b00;
    enable_nxt     = 2'b00;
    done_nxt       = 2'b00;
    err_nxt        = 2'b00;
    tx_en_nxt      = 1'b0;
    tx_data_nxt    = 8'h00;

    case (state)
      S_IDLE: begin
        if (o_pending != 2'b00) begin
          // A lone request wins outright; a tie goes to whoever was not granted last.
          if (o_pending == 2'b01)      sel_nxt = 1'b0;
          else if (o_pending == 2'b10) sel_nxt = 1'b1;
          else                         sel_nxt = ~last_grant;
          grant          = sel_nxt ? 2'b10 : 2'b01;
          enable_nxt     = grant;
          last_grant_nxt = sel_nxt;
          cnt_nxt        = '0;
          state_nxt      = S_START;
        end
      end
      S_START: begin
        if (g_en) begin
          tx_en_nxt   = 1'b1;
          tx_data_nxt = g_data;
          cnt_nxt     = CNT_W'(1);
          state_nxt   = S_SEND;
        end else if (cnt >= START_LAST) begin
          err_nxt   = sel_oh;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_SEND: begin
        if (!g_en) begin
          done_nxt  = sel_oh;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else if (cnt >= FRAME_MAX) begin
          // Overlong frame: cut the PHY stream now, wait for the generator to let go.
          state_nxt = S_DRAIN;
        end else begin
          tx_en_nxt   = 1'b1;
          tx_data_nxt = g_data;
          cnt_nxt     = cnt_inc;
        end
      end
      S_DRAIN: begin
        if (!g_en) begin
          err_nxt   = sel_oh;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt >= GAP_LAST) state_nxt = S_IDLE;
        else                 cnt_nxt   = cnt_inc;
      end
      default: state_nxt = S_IDLE;
    endcase

    pending_nxt = (o_pending & ~grant) | i_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      o_pending  <= 2'b00;
      o_enable   <= 2'b00;
      o_done     <= 2'b00;
      o_err      <= 2'b00;
      o_tx_en    <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      o_pending  <= pending_nxt;
      o_enable   <= enable_nxt;
      o_done     <= done_nxt;
      o_err      <= err_nxt;
      o_tx_en    <= tx_en_nxt;
      o_tx_data  <= tx_data_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - self-checking bench for eth_tx_sched
module tb_eth_tx_sched;

  localparam int IFG   = 12;
  localparam int STO   = 32;
  localparam int MAXF  = 1530;

  logic       clk;
  logic       rst_n;
  logic [1:0] i_req;
  logic [1:0] o_enable;
  logic [7:0] i_arp_tx_data;
  logic       i_arp_tx_en;
  logic [7:0] i_udp_tx_data;
  logic       i_udp_tx_en;
  logic [7:0] o_tx_data;
  logic       o_tx_en;
  logic       o_busy;
  logic [1:0] o_done;
  logic [1:0] o_err;
  logic [1:0] o_pending;

  eth_tx_sched #(
    .IFG_CYCLES(IFG), .START_TIMEOUT(STO), .MAX_FRAME(MAXF), .CNT_W(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .o_enable(o_enable),
    .i_arp_tx_data(i_arp_tx_data), .i_arp_tx_en(i_arp_tx_en),
    .i_udp_tx_data(i_udp_tx_data), .i_udp_tx_en(i_udp_tx_en),
    .o_tx_data(o_tx_data), .o_tx_en(o_tx_en), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_pending(o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    int         d;
    int         len;
    int         hi;
    logic [1:0] done;
    logic [1:0] err;
    int         pulse_k;
  } vec_t;

  vec_t vt[7];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic logic [7:0] fb(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [1:0] oh(input bit s);
    return s ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_gen(input bit s, input logic en, input logic [7:0] d);
    if (s) begin i_udp_tx_en = en; i_udp_tx_data = d; end
    else   begin i_arp_tx_en = en; i_arp_tx_data = d; end
  endtask

  task automatic quiet_gens;
    i_arp_tx_en = 1'b0; i_arp_tx_data = 8'h00;
    i_udp_tx_en = 1'b0; i_udp_tx_data = 8'h00;
  endtask

  task automatic do_reset;
    i_req = 2'b00;
    quiet_gens();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Starts in the cycle where the grant pulse should be visible; returns in the first IDLE cycle.
  task automatic run_frame(input bit s, input int d, input int len,
                           output int hi, output int pulse_k, output logic [1:0] pdone,
                           output logic [1:0] perr, output int busy_k, output int bad,
                           output int first_c, output int last_c);
    int k;
    hi = 0; pulse_k = -1; pdone = 2'b00; perr = 2'b00; busy_k = -1; bad = 0;
    first_c = -1; last_c = -1; k = 0;
    while (busy_k < 0 && k < 2100) begin
      if (k == 0) chk("grant_enable", 32'(o_enable), 32'(oh(s)));
      else if (o_enable != 2'b00) bad++;
      if (o_tx_en) begin
        if (o_tx_data !== fb(hi)) bad++;
        hi++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end else if (o_tx_data != 8'h00) bad++;
      if (o_done != 2'b00 || o_err != 2'b00) begin
        pdone   = pdone | o_done;
        perr    = perr | o_err;
        pulse_k = k;
      end
      if (k > 0 && !o_busy) begin
        busy_k = k;
      end else begin
        set_gen(!s, 1'($urandom), 8'($urandom));
        if (k >= d && k < d + len) set_gen(s, 1'b1, fb(k - d));
        else                       set_gen(s, 1'b0, 8'($urandom));
        tick();
        k++;
      end
    end
    quiet_gens();
  endtask

  task automatic run_vec(input int i);
    int hi, pk, bk, bad, fc, lc;
    logic [1:0] pd, pe;
    i_req = vt[i].req;
    tick();
    i_req = 2'b00;
    chk($sformatf("v%0d_pending", i), 32'(o_pending), 32'(vt[i].req));
    tick();
    run_frame(vt[i].req[1], vt[i].d, vt[i].len, hi, pk, pd, pe, bk, bad, fc, lc);
    chk($sformatf("v%0d_high_cycles", i), 32'(hi), 32'(vt[i].hi));
    chk($sformatf("v%0d_done", i), 32'(pd), 32'(vt[i].done));
    chk($sformatf("v%0d_err", i), 32'(pe), 32'(vt[i].err));
    chk($sformatf("v%0d_pulse_at", i), 32'(pk), 32'(vt[i].pulse_k));
    chk($sformatf("v%0d_idle_at", i), 32'(bk), 32'(vt[i].pulse_k + IFG));
    chk($sformatf("v%0d_stream_bad", i), 32'(bad), 32'd0);
  endtask

  // Reference model state for the randomized run (frame-level timeline arithmetic).
  logic [1:0] m_pend, grant_m;
  bit         m_last, m_sel, m_active, m_to, s_m;
  int         m_g, m_d, m_l, m_free, kk;
  logic [17:0] exp_v, act_v;
  logic [1:0] e_oh;

  initial begin
    int hi1, pk1, bk1, bad1, fc1, lc1, hi2, pk2, bk2, bad2, fc2, lc2;
    logic [1:0] pd1, pe1, pd2, pe2;
    logic e_en;
    logic [7:0] e_data;

    vt[0] = '{req: 2'b01, d: 3,   len: 60,   hi: 60,   done: 2'b01, err: 2'b00, pulse_k: 64};
    vt[1] = '{req: 2'b10, d: 0,   len: 1,    hi: 1,    done: 2'b10, err: 2'b00, pulse_k: 2};
    vt[2] = '{req: 2'b10, d: 255, len: 0,    hi: 0,    done: 2'b00, err: 2'b10, pulse_k: 32};
    vt[3] = '{req: 2'b01, d: 31,  len: 5,    hi: 5,    done: 2'b01, err: 2'b00, pulse_k: 37};
    vt[4] = '{req: 2'b01, d: 32,  len: 5,    hi: 0,    done: 2'b00, err: 2'b01, pulse_k: 32};
    vt[5] = '{req: 2'b10, d: 2,   len: 2000, hi: 1530, done: 2'b00, err: 2'b10, pulse_k: 2003};
    vt[6] = '{req: 2'b01, d: 1,   len: 1530, hi: 1530, done: 2'b01, err: 2'b00, pulse_k: 1532};

    rst_n = 1'b0;
    i_req = 2'b00;
    quiet_gens();
    do_reset();
    chk("reset_outputs", 32'({o_enable, o_tx_en, o_tx_data, o_busy, o_done, o_err, o_pending}), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Simultaneous requests after reset: ARP first, then UDP after the gap.
    do_reset();
    i_req = 2'b11;
    tick();
    i_req = 2'b00;
    chk("tie_pending", 32'(o_pending), 32'h3);
    tick();
    run_frame(1'b0, 0, 10, hi1, pk1, pd1, pe1, bk1, bad1, fc1, lc1);
    chk("tie_arp_done", 32'(pd1), 32'h1);
    chk("tie_pending_mid", 32'(o_pending), 32'h2);
    tick();
    chk("tie_pending_after", 32'(o_pending), 32'h0);
    run_frame(1'b1, 2, 8, hi2, pk2, pd2, pe2, bk2, bad2, fc2, lc2);
    chk("tie_udp_done", 32'(pd2), 32'h2);
    chk("tie_ifg_ok", 32'((fc2 - lc1 - 1) >= IFG), 32'h1);
    chk("tie_stream_bad", 32'(bad1 + bad2), 32'd0);

    // Reset mid-frame with a UDP request queued behind it.
    i_req = 2'b01;
    tick();
    i_req = 2'b00;
    tick();
    for (int k = 0; k < 10; k++) begin
      set_gen(1'b0, 1'b1, fb(k));
      i_req = (k == 4) ? 2'b10 : 2'b00;
      tick();
    end
    i_req = 2'b00;
    chk("rst_txen_before", 32'(o_tx_en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_txen_async", 32'(o_tx_en), 32'h0);
    quiet_gens();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_pending", 32'(o_pending), 32'h0);
    run_vec(0);

    // Randomized traffic against the timeline model.
    do_reset();
    m_pend = 2'b00; m_last = 1'b1; m_active = 1'b0; m_free = cyc;
    m_sel = 1'b0; m_to = 1'b0; m_g = 0; m_d = 0; m_l = 0;
    for (int n = 0; n < 3000; n++) begin
      kk   = cyc - m_g;
      e_oh = oh(m_sel);
      e_en = m_active && !m_to && kk >= m_d + 1 && kk <= m_d + m_l;
      e_data = e_en ? fb(kk - m_d - 1) : 8'h00;
      exp_v = {(m_active && kk == 0) ? e_oh : 2'b00,
               e_en, e_data,
               (m_active && !m_to && kk == m_d + m_l + 1) ? e_oh : 2'b00,
               (m_active && m_to && kk == STO) ? e_oh : 2'b00,
               (m_active && cyc < m_free),
               m_pend};
      act_v = {o_enable, o_tx_en, o_tx_data, o_done, o_err, o_busy, o_pending};
      chk("rand_cycle", 32'(act_v), 32'(exp_v));

      if (n < 1500) i_req = {($urandom % 16 == 0), ($urandom % 16 == 0)};
      else          i_req = 2'($urandom | 1);
      set_gen(1'b0, 1'($urandom), 8'($urandom));
      set_gen(1'b1, 1'($urandom), 8'($urandom));
      if (m_active && cyc < m_free) begin
        if (!m_to && kk >= m_d && kk < m_d + m_l) set_gen(m_sel, 1'b1, fb(kk - m_d));
        else                                      set_gen(m_sel, 1'b0, 8'($urandom));
      end

      grant_m = 2'b00;
      if (cyc >= m_free && m_pend != 2'b00) begin
        s_m      = (m_pend == 2'b11) ? !m_last : m_pend[1];
        grant_m  = oh(s_m);
        m_sel    = s_m;
        m_last   = s_m;
        m_active = 1'b1;
        m_g      = cyc + 1;
        m_d      = $urandom_range(0, 34);
        m_l      = $urandom_range(1, 40);
        m_to     = (m_d >= STO);
        m_free   = m_to ? m_g + STO + IFG : m_g + m_d + m_l + 1 + IFG;
      end
      m_pend = (m_pend & ~grant_m) | i_req;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
